// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// Optional feature macro: REGFILE_ZERO_REG_EN (hardwired-zero entry 0).
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int slice_lo(
    input int p,
    input int w
  );
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with write-first bypass.
// Optional feature macro: REGFILE_ZERO_REG_EN (handled in the top).
module regfile_read_port #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] arr_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          busy,
  output logic [DW-1:0] data,
  output logic          valid
);

  logic          hit;
  logic          fire;
  logic [DW-1:0] sel;

  // wr_en is the committed write, so a dropped write never bypasses
  assign hit  = wr_en && (wr_addr == addr);
  assign sel  = hit ? wr_data : arr_data;
  assign fire = en && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= fire;
      if (fire) data <= sel;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware clear sequencer.
// Optional feature macro: REGFILE_ZERO_REG_EN (hardwired-zero entry 0).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nx;
  logic                  wr_fire;

  logic [DATA_WIDTH-1:0] mem [FIRST:DEPTH-1];

  assign busy = (state == ST_CLEAR);

  // clear request wins over a same-cycle write
`ifdef REGFILE_ZERO_REG_EN
  assign wr_fire = (state == ST_IDLE) && wr_en && !clr_req &&
                   (wr_addr != '0);
`else
  assign wr_fire = (state == ST_IDLE) && wr_en && !clr_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(DEPTH - 1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = FIRST; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = FIRST; i < DEPTH; i++) begin
        if (busy && cnt == ADDR_WIDTH'(i))
          mem[i] <= '0;
        else if (wr_fire && wr_addr == ADDR_WIDTH'(i))
          mem[i] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] sel;

    assign ra = rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

    // entries below FIRST have no storage and read as zero
    always_comb begin
      sel = '0;
      for (int i = FIRST; i < DEPTH; i++)
        if (ra == ADDR_WIDTH'(i)) sel = mem[i];
    end

    regfile_read_port #(
      .DW(DATA_WIDTH),
      .AW(ADDR_WIDTH)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .en      (rd_en[p]),
      .addr    (ra),
      .arr_data(sel),
      .wr_en   (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .data    (rd_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH]),
      .valid   (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DATA_WIDTH=16, ADDR_WIDTH=3, NUM_RD=2).
// Honours REGFILE_ZERO_REG_EN when defined.
module tb_regfile_mp;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_req;
  logic        busy;

  regfile_mp #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .NUM_RD    (2)
  ) dut (
    .clk     (clk),
    .rst     (rst_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m [8];
  logic [15:0] last [2];
  bit          mbusy;
  int          mcnt;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '0;
    last[0] = '0;
    last[1] = '0;
    mbusy   = 1'b0;
    mcnt    = 0;
    exp_q.delete();
  endtask

  // drive one cycle, predict, then check after the edge
  task automatic cycle(input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] re,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic c);
    logic [2:0]  a [2];
    logic [1:0]  ev;
    logic [15:0] d;
    logic        wf;
    exp_t        e;
    a[0] = a0;
    a[1] = a1;
    ev   = '0;
    wf   = w && !mbusy && !c && !(ZR && wa == 3'd0);
    if (!mbusy) begin
      for (int p = 0; p < 2; p++) begin
        if (re[p]) begin
          ev[p] = 1'b1;
          d = (wf && wa == a[p]) ? wd : m[a[p]];
          if (ZR && a[p] == 3'd0) d = '0;
          e.port = p;
          e.data = d;
          exp_q.push_back(e);
          last[p] = d;
        end
      end
    end
    if (mbusy) begin
      m[mcnt] = '0;
      if (mcnt == 7) mbusy = 1'b0;
      mcnt++;
    end else if (c) begin
      mbusy = 1'b1;
      mcnt  = 0;
    end else if (wf) begin
      m[wa] = wd;
    end
    wr_en   = w;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    clr_req = c;
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(mbusy));
    for (int p = 0; p < 2; p++) begin
      chk("rd_data_hold", 32'(rd_data[p*16 +: 16]), 32'(last[p]));
      if (rd_valid[p]) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_port", 32'(e.port), 32'(p));
          chk("sb_data", 32'(rd_data[p*16 +: 16]), 32'(e.data));
        end
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    int n;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_valid", 32'(rd_valid), 32'(0));
    chk("reset_data", rd_data, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // write then read with latency 1, single-cycle valid
    cycle(1'b1, 3'd5, 16'hBEEF, 2'b00, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 16'h0, 2'b01, 3'd5, 3'd0, 1'b0);
    chk("read5", 32'(rd_data[15:0]), 32'h0000BEEF);
    chk("read5_valid", 32'(rd_valid), 32'(2'b01));
    idle();
    chk("read5_pulse", 32'(rd_valid), 32'(0));

    // same-cycle write/read bypass on both ports
    cycle(1'b1, 3'd3, 16'h1234, 2'b11, 3'd3, 3'd3, 1'b0);
    chk("byp_p0", 32'(rd_data[15:0]), 32'h00001234);
    chk("byp_p1", 32'(rd_data[31:16]), 32'h00001234);

    // fill, then clear with a colliding write and same-cycle read
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 3'(i), 16'(16'h1111 * i), 2'b00, 3'd0, 3'd0, 1'b0);
    cycle(1'b1, 3'd2, 16'hAAAA, 2'b01, 3'd4, 3'd0, 1'b1);
    chk("clr_rd_served", 32'(rd_data[15:0]), 32'h00004444);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      n++;
      cycle(1'b1, 3'(k), 16'h5A5A, 2'b11, 3'(k), 3'(7 - k), 1'b0);
    end
    chk("busy_cycles", 32'(n), 32'(8));
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 3'd0, 16'h0, 2'b11, 3'(i), 3'(7 - i), 1'b0);
    cycle(1'b0, 3'd0, 16'h0, 2'b01, 3'd2, 3'd0, 1'b0);
    chk("clr_addr2", 32'(rd_data[15:0]), 32'(0));

    // asynchronous reset in the 4th cycle of a clear
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 3'(i), 16'(16'h0101 * (i + 1)), 2'b00, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 16'h0, 2'b11, 3'd7, 3'd6, 1'b1);
    repeat (3) cycle(1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_valid", 32'(rd_valid), 32'(0));
    chk("arst_data", rd_data, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 3'd6, 16'h00FF, 2'b00, 3'd0, 3'd0, 1'b0);
    chk("post_rst_idle", 32'(busy), 32'(0));
    cycle(1'b0, 3'd0, 16'h0, 2'b11, 3'd7, 3'd6, 1'b0);
    chk("post_rst_a7", 32'(rd_data[15:0]), 32'(0));
    chk("post_rst_a6", 32'(rd_data[31:16]), 32'h000000FF);

    // entry 0: ordinary or hardwired zero
    cycle(1'b1, 3'd0, 16'hFFFF, 2'b01, 3'd0, 3'd0, 1'b0);
    chk("zr_bypass", 32'(rd_data[15:0]), ZR ? 32'(0) : 32'h0000FFFF);
    cycle(1'b0, 3'd0, 16'h0, 2'b10, 3'd0, 3'd0, 1'b0);
    chk("zr_read", 32'(rd_data[31:16]), ZR ? 32'(0) : 32'h0000FFFF);
    idle();
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file. It is the next generation of the single-port, decoder-based register file.
- Supports NUM_RD independent synchronous read ports, one write port and write-first bypass.
- Provides a hardware clear sequencer that zeroes the array one entry per cycle.
- Sits between decode and execute as the architectural register store of the lab datapath.

Parameters:
- DATA_WIDTH, 16, width of each register in bits.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data.
- rd_valid  out  NUM_RD  per-port one-cycle pulse, high when rd_data[p] carries a fresh read.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- clr_req  in  1  request to zero the whole array.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - All DEPTH registers, rd_data, rd_valid, busy and the clear counter go to 0.
  - The FSM goes to IDLE.
  - Deassertion is synchronous to clk.
- FSM states:
  - IDLE: normal operation.
  - CLEAR: sequencer active.
- IDLE transitions:
  - clr_req=1 at edge t: go to CLEAR, counter=0, busy=1 from t+1.
  - A wr_en in the same cycle is dropped (clear has priority).
  - rd_en in that cycle is still served normally.
- CLEAR:
  - At each edge, reg[counter] <= 0 and counter increments.
  - When counter==DEPTH-1, that entry is zeroed, the FSM returns to IDLE and busy=0 at the following cycle.
  - busy is high for exactly DEPTH cycles.
- While busy:
  - wr_en is ignored (no write).
  - rd_en is ignored: rd_valid=0 and rd_data holds its last value.
  - clr_req is ignored (no restart).
- Write: in IDLE, wr_en=1 at edge t sets reg[wr_addr] <= wr_data. The new value is visible to reads issued at t+1.
- Read:
  - rd_en[p]=1 at edge t: rd_data[p] is updated at t, i.e. it is valid during cycle t+1 (latency 1).
  - rd_valid[p]=1 for that one cycle.
  - rd_en[p]=0: rd_valid[p]=0 and rd_data[p] holds its last value.
- Bypass: if rd_en[p], wr_en and rd_addr[p]==wr_addr in the same IDLE cycle, rd_data[p] returns wr_data (write-first).
- Multiple read ports may address the same or different entries in the same cycle with no conflict.
- Reset asserted mid-clear: the sequence aborts, the array is fully zeroed by reset, and the FSM goes to IDLE.
- Address wrap: none needed; all ADDR_WIDTH values are legal.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to address 0 are discarded.
  - Reads of address 0 return 0, including when the bypass condition matches wr_addr=0 with nonzero wr_data.
  - No storage is inferred for entry 0.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Package regfile_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR).
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - Helper function for packed-slice indexing.
- Sub-module regfile_read_port, instantiated NUM_RD times via generate.
  - Contains the bypass compare/mux, the output data register and the rd_valid flop.
  - Inputs: array-selected data, write-port signals, busy.
- Top level holds the storage array, write decode, clear FSM and counter.

Test Plan:
- Reset, then write 0xBEEF to addr 5; next cycle read port0 addr 5 -> one cycle later rd_data[0]=0xBEEF, rd_valid[0]=1 for exactly one cycle.
- Same cycle: wr addr 3 data 0x1234, port0 rd addr 3, port1 rd addr 3 -> both return 0x1234 (bypass).
- Fill all 8 entries with 0x1111*i, pulse clr_req -> busy high exactly 8 cycles; wr_en during busy has no effect; reads issued afterwards return 0 for all entries.
- clr_req and wr_en (addr 2, 0xAAAA) in the same cycle -> write dropped; after clear, addr 2 reads 0.
- Drop rst to 0 at the 4th cycle of CLEAR -> busy=0 and rd_valid=0 immediately (asynchronous); after release, FSM is IDLE and a write/read to addr 6 of 0x00FF works.
- With REGFILE_ZERO_REG_EN: write 0xFFFF to addr 0 with a same-cycle read of addr 0 -> rd_data=0; a later read also returns 0. Without the macro -> 0xFFFF both times.
